// File: rtl/bsg_wormhole_packet_assembler.sv
// Wormhole endpoint consumer: takes one header flit plus len body flits and
// presents the reassembled packet to a client over a valid/yumi handshake.
module bsg_wormhole_packet_assembler #(
  parameter int unsigned flit_width_p        = 32,
  parameter int unsigned cord_width_p        = 6,
  parameter int unsigned len_width_p         = 3,
  parameter int unsigned max_payload_flits_p = 4
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  // link layout: {v, data[flit_width_p-1:0], ready_and_rev}
  input  logic [flit_width_p+1:0]                       link_i,
  output logic [flit_width_p+1:0]                       link_o,
  output logic                                          packet_v_o,
  output logic [flit_width_p-1:0]                       packet_header_o,
  output logic [len_width_p-1:0]                        packet_len_o,
  output logic [max_payload_flits_p*flit_width_p-1:0]   packet_data_o,
  output logic                                          packet_overflow_o,
  input  logic                                          packet_yumi_i
);

  localparam logic [len_width_p-1:0] LP_MAX = len_width_p'(max_payload_flits_p);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_BODY = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  state_e                                    r_state;
  logic                                      r_ready;
  logic [len_width_p-1:0]                    r_rem;
  logic [len_width_p-1:0]                    r_idx;
  logic [flit_width_p-1:0]                   r_header;
  logic [len_width_p-1:0]                    r_len;
  logic [max_payload_flits_p*flit_width_p-1:0] r_data;
  logic                                      r_ovf;

  logic                    w_v;
  logic [flit_width_p-1:0] w_flit;
  logic                    w_xfer;
  logic [len_width_p-1:0]  w_len;
  logic                    w_unused_rev;

  assign w_v          = link_i[flit_width_p+1];
  assign w_flit       = link_i[flit_width_p:1];
  assign w_unused_rev = link_i[0];
  assign w_xfer       = w_v & r_ready;
  assign w_len        = w_flit[cord_width_p +: len_width_p];

  // ready is its own register so it stays low throughout reset and rises on
  // the first edge after release, while still equalling (state != FULL).
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= ST_HDR;
      r_ready  <= 1'b0;
      r_rem    <= '0;
      r_idx    <= '0;
      r_header <= '0;
      r_len    <= '0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_HDR: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_header <= w_flit;
            r_len    <= w_len;
            r_data   <= '0;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
            if (w_len == '0) begin
              r_state <= ST_FULL;
              r_ready <= 1'b0;
            end else begin
              r_rem   <= w_len;
              r_state <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            if (r_idx < LP_MAX) begin
              for (int unsigned k = 0; k < max_payload_flits_p; k++) begin
                if (r_idx == len_width_p'(k))
                  r_data[k*flit_width_p +: flit_width_p] <= w_flit;
              end
            end else begin
              r_ovf <= 1'b1;
            end
            r_idx <= r_idx + len_width_p'(1);
            r_rem <= r_rem - len_width_p'(1);
            if (r_rem == len_width_p'(1)) begin
              r_state <= ST_FULL;
              r_ready <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          if (packet_yumi_i) begin
            r_state <= ST_HDR;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_HDR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign link_o            = {1'b0, {flit_width_p{1'b0}}, r_ready};
  assign packet_v_o        = (r_state == ST_FULL);
  assign packet_header_o   = r_header;
  assign packet_len_o      = r_len;
  assign packet_data_o     = r_data;
  assign packet_overflow_o = r_ovf;

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
    packet_yumi_i |-> (r_state == ST_FULL));

endmodule

// File: tb/tb_bsg_wormhole_packet_assembler.sv
// Scoreboard bench for bsg_wormhole_packet_assembler: stimulus pushes expected
// packets, a negedge monitor pops and compares whenever packet_v_o is seen.
module tb_bsg_wormhole_packet_assembler;
  localparam int unsigned FW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned LW = 3;
  localparam int unsigned MX = 4;

  typedef struct {
    logic [FW-1:0]    hdr;
    logic [LW-1:0]    len;
    logic [MX*FW-1:0] data;
    logic             ovf;
  } pkt_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              link_v = 1'b0;
  logic [FW-1:0]     link_d = '0;
  logic [FW+1:0]     link_i;
  logic [FW+1:0]     link_o;
  logic              pv;
  logic [FW-1:0]     phdr;
  logic [LW-1:0]     plen;
  logic [MX*FW-1:0]  pdata;
  logic              povf;
  logic              yumi = 1'b0;
  logic              ready;

  int   checks = 0;
  int   errors = 0;
  pkt_t q[$];
  pkt_t cur;
  logic seen = 1'b0;

  assign link_i = {link_v, link_d, 1'b0};
  assign ready  = link_o[0];

  always #5 clk = ~clk;

  bsg_wormhole_packet_assembler #(
    .flit_width_p(FW),
    .cord_width_p(CW),
    .len_width_p(LW),
    .max_payload_flits_p(MX)
  ) dut (
    .clk_i(clk),
    .reset_i(rst_n),
    .link_i(link_i),
    .link_o(link_o),
    .packet_v_o(pv),
    .packet_header_o(phdr),
    .packet_len_o(plen),
    .packet_data_o(pdata),
    .packet_overflow_o(povf),
    .packet_yumi_i(yumi)
  );

  task automatic chk(input string name, input logic [MX*FW-1:0] act, input logic [MX*FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: first valid cycle pops the expected packet; later valid cycles
  // check the outputs are still held.
  always @(negedge clk) begin
    if (!pv) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_packet got hdr %h want none", phdr);
        end else begin
          cur  = q.pop_front();
          seen = 1'b1;
        end
      end
      if (seen) begin
        chk("sb_header", phdr, cur.hdr);
        chk("sb_len", plen, cur.len);
        chk("sb_data", pdata, cur.data);
        chk("sb_overflow", povf, cur.ovf);
      end
    end
  end

  task automatic push(input logic [FW-1:0] h, input logic [LW-1:0] l,
                      input logic [MX*FW-1:0] d, input logic o);
    pkt_t p;
    p.hdr = h; p.len = l; p.data = d; p.ovf = o;
    q.push_back(p);
  endtask

  // Called at a negedge; returns at the negedge after the flit transfers.
  task automatic send(input logic [FW-1:0] f);
    int tries = 0;
    link_v = 1'b1;
    link_d = f;
    while (!ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready 0 want 1");
    end
    @(negedge clk);
  endtask

  task automatic consume();
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_v", pv, 0);
    chk("rst_ready", ready, 0);
    chk("rst_header", phdr, 0);
    chk("rst_data", pdata, 0);
    chk("rst_ovf", povf, 0);
    rst_n = 1'b1;
    #1 chk("rst_release_ready", ready, 0);
    @(negedge clk);
    chk("ready_after_release", ready, 1);

    // zero-length packet
    push(32'h0000_0005, 3'd0, '0, 1'b0);
    send(32'h0000_0005);
    link_v = 1'b0;
    chk("lat_zero", pv, 1);
    consume();

    // full packet, len=3 with junk in upper header bits
    push(32'h1230_00C2, 3'd3, {32'h0, 32'hA3, 32'hA2, 32'hA1}, 1'b0);
    send(32'h1230_00C2);
    send(32'hA1); send(32'hA2); send(32'hA3);
    link_v = 1'b0;
    chk("lat_full", pv, 1);
    repeat (3) begin
      chk("full_ready_low", ready, 0);
      @(negedge clk);
    end
    consume();

    // overflow: len=6, only four slots kept
    push(32'h0000_0181, 3'd6, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 1'b1);
    send(32'h0000_0181);
    for (int i = 1; i <= 6; i++) send(32'hB0 + 32'(i));
    link_v = 1'b0;
    chk("lat_ovf", pv, 1);
    consume();

    // backpressure with a zero-length header pending
    push(32'h0000_00C4, 3'd3, {32'h0, 32'hD3, 32'hD2, 32'hD1}, 1'b0);
    send(32'h0000_00C4);
    send(32'hD1); send(32'hD2); send(32'hD3);
    push(32'h0000_0011, 3'd0, '0, 1'b0);
    link_v = 1'b1;
    link_d = 32'h0000_0011;
    repeat (10) begin
      chk("bp_ready", ready, 0);
      chk("bp_valid", pv, 1);
      @(negedge clk);
    end
    consume();
    chk("bp_bubble_v", pv, 0);
    chk("bp_bubble_ready", ready, 1);
    @(negedge clk);
    link_v = 1'b0;
    chk("bp_hdr_one_cycle", pv, 1);
    consume();

    // gapped input: v pattern 1,0,0,1 on the body flits
    push(32'h0000_0083, 3'd2, {32'h0, 32'h0, 32'hE2, 32'hE1}, 1'b0);
    send(32'h0000_0083);
    send(32'hE1);
    link_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("gap_no_early_v", pv, 0);
    send(32'hE2);
    link_v = 1'b0;
    chk("lat_gap", pv, 1);
    consume();

    // async reset mid-body; the partial packet is never expected
    send(32'h0000_00C9);
    send(32'hF1);
    link_v = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", pv, 0);
    chk("arst_ready", ready, 0);
    chk("arst_header", phdr, 0);
    chk("arst_len", plen, 0);
    chk("arst_data", pdata, 0);
    chk("arst_ovf", povf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready_back", ready, 1);
    push(32'h0000_0047, 3'd1, {32'h0, 32'h0, 32'h0, 32'hC1}, 1'b0);
    send(32'h0000_0047);
    send(32'hC1);
    link_v = 1'b0;
    chk("lat_after_rst", pv, 1);
    consume();

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
